// File: rtl/adc_stream_ctrl_if.sv
// rtl/adc_stream_ctrl_if.sv - Avalon-MM bus bundle between the ADC stream controller and the sequencer CSR
//
// Purpose: groups the Avalon-MM master command/response signals used to start,
//          poll and stop the ADC sequencer.
// Signals:
//   avm_address[9:0], avm_write, avm_read, avm_writedata[15:0],
//   avm_byteenable[1:0], avm_burstcount, avm_debugaccess  master -> slave
//   avm_waitrequest, avm_readdata[15:0], avm_readdatavalid slave -> master
// Modports: master (controller side), slave (bridge/sequencer side).

interface adc_stream_ctrl_if;
  logic [9:0]  avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic        avm_burstcount;
  logic        avm_debugaccess;
  logic        avm_waitrequest;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address, avm_write, avm_read, avm_writedata,
           avm_byteenable, avm_burstcount, avm_debugaccess,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_write, avm_read, avm_writedata,
           avm_byteenable, avm_burstcount, avm_debugaccess,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/adc_stream_ctrl.sv
// rtl/adc_stream_ctrl.sv - ADC sequencer run/stop controller with per-channel sample averaging
//
// Purpose: starts the ADC sequencer through its CSR (write 1, read back and
//          confirm bit0), keeps it running while enable is high, stops it
//          (write 0) when enable drops, and averages 2^AVG_LOG2 response beats
//          of the selected channel while running.
// Ports:
//   clk_clk, reset_reset_n            clock, async active-low reset
//   enable                            request sequencer run
//   sel_ch[4:0]                       channel to average
//   rsp_valid/startofpacket/endofpacket, rsp_channel[4:0], rsp_data[11:0]
//                                     ADC response stream (always accepted)
//   avm                               Avalon-MM master (adc_stream_ctrl_if.master)
//   sample_strobe, sample_ch[4:0], sample_avg[11:0]
//                                     averaged sample, strobe valid one cycle
//   seq_running, err_flag             status

module adc_stream_ctrl #(
  parameter logic [9:0] CSR_ADDR = 10'h000,
  parameter int         AVG_LOG2 = 2,
  parameter int         TIMEOUT  = 255
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic                     enable,
  input  logic [4:0]               sel_ch,
  input  logic                     rsp_valid,
  input  logic                     rsp_startofpacket,
  input  logic                     rsp_endofpacket,
  input  logic [4:0]               rsp_channel,
  input  logic [11:0]              rsp_data,
  adc_stream_ctrl_if.master        avm,
  output logic                     sample_strobe,
  output logic [4:0]               sample_ch,
  output logic [11:0]              sample_avg,
  output logic                     seq_running,
  output logic                     err_flag
);

  localparam int              TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [4:0]      COUNT_LAST = 5'((1 << AVG_LOG2) - 1);
  localparam logic [15:0]     CSR_RUN    = 16'h0001;
  localparam logic [15:0]     CSR_STOP   = 16'h0000;

  typedef enum logic [2:0] {
    IDLE,
    WR_RUN,
    RD_REQ,
    RD_WAIT,
    RUN,
    WR_STOP,
    ERROR
  } state_t;

  state_t         state;
  logic [1:0]     retry;      // failed readbacks so far in this start sequence
  logic [TW-1:0]  timer;
  logic           stop_req;   // enable dropped while a start command was in flight

  logic [15:0]    acc;
  logic [4:0]     count;
  logic [4:0]     sel_ch_q;
  logic [15:0]    sum;
  logic           stop_now;

  assign avm.avm_byteenable  = 2'b11;
  assign avm.avm_burstcount  = 1'b1;
  assign avm.avm_debugaccess = 1'b0;

  // Only bit0 of the CSR readback matters; packet framing is irrelevant to averaging.
  logic unused_bits;
  assign unused_bits = ^{avm.avm_readdata[15:1], rsp_startofpacket, rsp_endofpacket};

  assign stop_now = stop_req || !enable;
  assign sum      = acc + {4'b0000, rsp_data};

  // Sequencer control FSM. Bus commands are registered and held until
  // waitrequest is seen low on a clock edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state             <= IDLE;
      avm.avm_write     <= 1'b0;
      avm.avm_read      <= 1'b0;
      avm.avm_address   <= 10'h000;
      avm.avm_writedata <= 16'h0000;
      seq_running       <= 1'b0;
      err_flag          <= 1'b0;
      retry             <= 2'd0;
      timer             <= '0;
      stop_req          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stop_req    <= 1'b0;
          seq_running <= 1'b0;
          if (enable) begin
            state             <= WR_RUN;
            avm.avm_write     <= 1'b1;
            avm.avm_address   <= CSR_ADDR;
            avm.avm_writedata <= CSR_RUN;
            retry             <= 2'd0;
          end
        end

        WR_RUN: begin
          if (!enable) stop_req <= 1'b1;
          if (!avm.avm_waitrequest) begin
            if (stop_now) begin
              // Back-to-back stop write; the run write has just completed.
              state             <= WR_STOP;
              avm.avm_writedata <= CSR_STOP;
            end else begin
              state         <= RD_REQ;
              avm.avm_write <= 1'b0;
              avm.avm_read  <= 1'b1;
            end
          end
        end

        RD_REQ: begin
          if (!enable) stop_req <= 1'b1;
          if (!avm.avm_waitrequest) begin
            avm.avm_read <= 1'b0;
            if (stop_now) begin
              state             <= WR_STOP;
              avm.avm_write     <= 1'b1;
              avm.avm_writedata <= CSR_STOP;
            end else begin
              state <= RD_WAIT;
              timer <= '0;
            end
          end
        end

        RD_WAIT: begin
          if (!enable) stop_req <= 1'b1;
          if (avm.avm_readdatavalid) begin
            if (stop_now) begin
              state             <= WR_STOP;
              avm.avm_write     <= 1'b1;
              avm.avm_writedata <= CSR_STOP;
            end else if (avm.avm_readdata[0]) begin
              state       <= RUN;
              seq_running <= 1'b1;
            end else if (retry == 2'd2) begin
              state    <= ERROR;
              err_flag <= 1'b1;
            end else begin
              retry             <= retry + 2'd1;
              state             <= WR_RUN;
              avm.avm_write     <= 1'b1;
              avm.avm_writedata <= CSR_RUN;
            end
          end else if (timer == TIMER_LAST) begin
            state    <= ERROR;
            err_flag <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        RUN: begin
          if (!enable) begin
            state             <= WR_STOP;
            seq_running       <= 1'b0;
            avm.avm_write     <= 1'b1;
            avm.avm_address   <= CSR_ADDR;
            avm.avm_writedata <= CSR_STOP;
          end
        end

        WR_STOP: begin
          if (!avm.avm_waitrequest) begin
            state         <= IDLE;
            avm.avm_write <= 1'b0;
          end
        end

        ERROR: begin
          if (!enable) begin
            state    <= IDLE;
            err_flag <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Averaging of the selected channel. A window only completes with
  // uninterrupted RUN time and a stable sel_ch; anything else restarts it.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      acc           <= 16'h0000;
      count         <= 5'd0;
      sel_ch_q      <= 5'd0;
      sample_strobe <= 1'b0;
      sample_avg    <= 12'h000;
      sample_ch     <= 5'd0;
    end else begin
      sel_ch_q      <= sel_ch;
      sample_strobe <= 1'b0;
      if (state != RUN || sel_ch != sel_ch_q) begin
        acc   <= 16'h0000;
        count <= 5'd0;
      end else if (rsp_valid && rsp_channel == sel_ch) begin
        if (count == COUNT_LAST) begin
          sample_avg    <= 12'(sum >> AVG_LOG2);
          sample_ch     <= sel_ch;
          sample_strobe <= 1'b1;
          acc           <= 16'h0000;
          count         <= 5'd0;
        end else begin
          acc   <= sum;
          count <= count + 5'd1;
        end
      end
    end
  end

endmodule

// File: doc/adc_stream_ctrl.md
ADC_STREAM_CTRL -- requirements
Module: adc_stream_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter CSR_ADDR, default 10'h000, sequencer CSR word address on the bridge.
REQ-002 The block SHALL have parameter AVG_LOG2, default 2, log2 of averaging window (range 0..4).
REQ-003 The block SHALL have parameter TIMEOUT, default 255, max cycles waiting for readdatavalid.

Ports:
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk_clk  in  1  clock; reset_reset_n  in  1  async active-low reset.
REQ-005 The block SHALL have port enable  in  1  request sequencer run.
REQ-006 The block SHALL have port sel_ch  in  5  channel to average.
REQ-007 The block SHALL have ports rsp_valid, rsp_startofpacket, rsp_endofpacket  in  1 each  ADC response stream qualifiers; no ready, so every valid beat is accepted.
REQ-008 The block SHALL have ports rsp_channel  in  5  and rsp_data  in  12  for the ADC response stream.
REQ-009 The block SHALL have Avalon-MM master outputs: avm_address 10, avm_write 1, avm_read 1, avm_writedata 16, avm_byteenable 2 (fixed 2'b11), avm_burstcount 1 (fixed 1'b1), avm_debugaccess 1 (fixed 0).
REQ-010 The block SHALL have Avalon-MM master inputs: avm_waitrequest 1, avm_readdata 16, avm_readdatavalid 1.
REQ-011 The block SHALL have outputs sample_strobe 1 (one-cycle average valid), sample_ch 5, sample_avg 12, seq_running 1, err_flag 1.

Function
REQ-012 The FSM SHALL have states IDLE, WR_RUN, RD_REQ, RD_WAIT, RUN, WR_STOP, ERROR.
REQ-013 IDLE: enable=1 -> WR_RUN, with avm_write=1, address=CSR_ADDR, writedata=16'h0001.
REQ-014 All commands SHALL be held stable while avm_waitrequest=1; a command completes on the first cycle with waitrequest=0.
REQ-015 WR_RUN complete -> RD_REQ: avm_read=1, address=CSR_ADDR; read complete -> RD_WAIT.
REQ-016 RD_WAIT: on readdatavalid, bit0=1 -> RUN; bit0=0 -> retry from WR_RUN, max 3 attempts, then ERROR.
REQ-017 RD_WAIT timeout: no readdatavalid within TIMEOUT cycles -> ERROR.
REQ-018 readdatavalid outside RD_WAIT SHALL be ignored.
REQ-019 RUN: seq_running=1; enable=0 -> WR_STOP, writedata=16'h0000; complete -> IDLE.
REQ-020 enable=0 during WR_RUN/RD_REQ SHALL NOT abort the bus command; after completion go to WR_STOP.
REQ-021 ERROR: err_flag=1, no bus activity; exits only when enable=0 -> IDLE, err_flag cleared.
REQ-022 Stream beats SHALL be accumulated only in RUN, and only when rsp_valid=1 and rsp_channel==sel_ch; other beats are discarded.
REQ-023 The accumulator SHALL be 16 bits, unsigned; a counter tracks 2^AVG_LOG2 samples.
REQ-024 On the last sample of a window: sample_avg=(acc+data)>>AVG_LOG2 (truncate), sample_ch=sel_ch, and sample_strobe=1 in the next cycle for exactly one cycle; acc and count clear in the same edge.
REQ-025 A sel_ch change, or leaving RUN, SHALL clear acc/count without strobe.
REQ-026 sample_avg/sample_ch SHALL hold their last value between strobes.
REQ-027 startofpacket/endofpacket SHALL be ignored for averaging.

Reset
REQ-028 Async assert SHALL force: state=IDLE, avm_write=0, avm_read=0, avm_address=0, avm_writedata=0, sample_strobe=0, sample_avg=0, sample_ch=0, seq_running=0, err_flag=0, acc=0, count=0, retry=0, timer=0.
REQ-029 Reset mid bus command SHALL drop the command immediately, and no write is reissued after release until enable is seen high in IDLE.

Verification
REQ-030 enable 0->1, waitrequest high 3 cycles, readdata=16'h0001 -> one write 16'h0001 held 4 cycles, one read, seq_running=1.
REQ-031 RUN, AVG_LOG2=2, sel_ch=3, ch3 data 100,101,102,103 interleaved with ch5 beats -> single strobe, sample_avg=101, sample_ch=3.
REQ-032 Readback 16'h0000 three times -> err_flag=1 after third read, no further bus activity; enable=0 -> IDLE, err_flag=0.
REQ-033 No readdatavalid for 256 cycles -> ERROR at TIMEOUT expiry.
REQ-034 sel_ch changes after 2 samples -> no strobe; 4 more samples on the new channel -> one strobe with their average.
REQ-035 reset_reset_n low during WR_RUN with waitrequest=1 -> avm_write=0 asynchronously, all outputs at reset values.
